// File: rtl/sseg_disp_mux_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display driver.
package sseg_disp_mux_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  typedef logic [3:0] nibble_t;

  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Index/counter width that never collapses to zero bits.
  function automatic int dig_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sseg_disp_mux_if.sv
// Datapath-side load bus and board-side display pins of the digit scanner.
interface sseg_disp_mux_if #(
  parameter int N_DIGITS = 8
);
  import sseg_disp_mux_pkg::*;

  logic                          load;
  logic [4*N_DIGITS-1:0]         hex_in;
  logic [N_DIGITS-1:0]           dp_in;
  logic [N_DIGITS-1:0]           en_in;
  logic [N_DIGITS-1:0]           an_n;
  nibble_t                       hex_out;
  logic                          dp_n;
  logic [dig_w(N_DIGITS)-1:0]    dig_idx;

  modport master (
    output load, hex_in, dp_in, en_in,
    input  an_n, hex_out, dp_n, dig_idx
  );

  modport slave (
    input  load, hex_in, dp_in, en_in,
    output an_n, hex_out, dp_n, dig_idx
  );

endinterface

// File: rtl/sseg_disp_mux_refresh_tick.sv
// Free-running slot counter: flags its programmable terminal count and
// restarts from zero on a synchronous clear.
module sseg_disp_mux_refresh_tick #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == i_last);

endmodule

// File: rtl/sseg_disp_mux.sv
// Time-multiplexed common-anode 7-segment driver: shadows a packed hex word,
// scans one digit per slot with optional dark gap, emits nibble for hex2sseg.
module sseg_disp_mux
  import sseg_disp_mux_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100_000,
  parameter int GAP_CYC     = 16,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  sseg_disp_mux_if.slave bus
);

  localparam int IDX_W = dig_w(N_DIGITS);
  localparam int CNT_W = dig_w(max_i(REFRESH_DIV, GAP_CYC));
  localparam logic [CNT_W-1:0]    SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = AN_OFF[N_DIGITS-1:0];

  logic [4*N_DIGITS-1:0] r_hex;
  logic [N_DIGITS-1:0]   r_dp;
  logic [N_DIGITS-1:0]   r_en;

  scan_state_t           r_state;
  scan_state_t           w_state_nxt;
  logic [IDX_W-1:0]      r_dig;
  logic [IDX_W-1:0]      w_dig_nxt;
  logic [IDX_W-1:0]      w_dig_inc;
  logic [CNT_W-1:0]      w_last;
  logic                  w_tc;

  logic                  w_upper_nz;
  logic                  w_blank;
  nibble_t               w_nib;
  logic [N_DIGITS-1:0]   w_an_nxt;
  logic                  w_dp_nxt;
  nibble_t               w_hex_nxt;

  logic [N_DIGITS-1:0]   r_an_n;
  nibble_t               r_hex_out;
  logic                  r_dp_n;
  logic [IDX_W-1:0]      r_dig_idx;

  // NOTE: the shadow is a few flops rather than a RAM, so it takes the async
  // reset and a freshly reset display shows nothing (all enables cleared).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex <= '0;
      r_dp  <= '0;
      r_en  <= '0;
    end else if (bus.load) begin
      r_hex <= bus.hex_in;
      r_dp  <= bus.dp_in;
      r_en  <= bus.en_in;
    end
  end

  assign w_last = (r_state == SHOW) ? SHOW_LAST : GAP_LAST;

  sseg_disp_mux_refresh_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_tc),
    .i_last  (w_last),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SHOW;
      r_dig   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dig   <= w_dig_nxt;
    end
  end

  assign w_dig_inc = (r_dig == IDX_LAST) ? '0 : r_dig + 1'b1;

  // NOTE: defaults assigned first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_dig_nxt   = r_dig;
    if (w_tc) begin
      case (r_state)
        SHOW: begin
          if (GAP_CYC > 0) w_state_nxt = GAP;
          else             w_dig_nxt   = w_dig_inc;
        end
        GAP: begin
          w_state_nxt = SHOW;
          w_dig_nxt   = w_dig_inc;
        end
        default: w_state_nxt = SHOW;
      endcase
    end
  end

  // Leading-zero test: this digit and every more-significant one are zero.
  always_comb begin
    w_upper_nz = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(r_dig) && r_hex[4*i +: 4] != 4'h0) w_upper_nz = 1'b1;
    end
  end

  assign w_nib   = r_hex[4*int'(r_dig) +: 4];
  assign w_blank = !r_en[r_dig] || (LZ_BLANK && (r_dig != '0) && !w_upper_nz);

  always_comb begin
    w_an_nxt  = AN_ALL_OFF;
    w_dp_nxt  = 1'b1;
    w_hex_nxt = w_nib;
    if (r_state == SHOW && !w_blank) begin
      w_an_nxt[r_dig] = 1'b0;
      w_dp_nxt        = ~r_dp[r_dig];
    end
  end

  // Pin registers lag the scan state by one cycle, keeping the pins glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an_n    <= AN_ALL_OFF;
      r_hex_out <= '0;
      r_dp_n    <= 1'b1;
      r_dig_idx <= '0;
    end else begin
      r_an_n    <= w_an_nxt;
      r_hex_out <= w_hex_nxt;
      r_dp_n    <= w_dp_nxt;
      r_dig_idx <= r_dig;
    end
  end

  assign bus.an_n    = r_an_n;
  assign bus.hex_out = r_hex_out;
  assign bus.dp_n    = r_dp_n;
  assign bus.dig_idx = r_dig_idx;

endmodule

// File: tb/tb_sseg_disp_mux.sv
// Directed bench for sseg_disp_mux: three configurations (gap, leading-zero
// blanking, no gap) driven by one stimulus stream against a slot-timing model.
module tb_sseg_disp_mux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [31:0] hex_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;

  always #5 clk = ~clk;

  sseg_disp_mux_if #(.N_DIGITS(8)) bus_a ();
  sseg_disp_mux_if #(.N_DIGITS(8)) bus_l ();
  sseg_disp_mux_if #(.N_DIGITS(8)) bus_g ();

  assign bus_a.load = load;  assign bus_a.hex_in = hex_in;
  assign bus_a.dp_in = dp_in; assign bus_a.en_in = en_in;
  assign bus_l.load = load;  assign bus_l.hex_in = hex_in;
  assign bus_l.dp_in = dp_in; assign bus_l.en_in = en_in;
  assign bus_g.load = load;  assign bus_g.hex_in = hex_in;
  assign bus_g.dp_in = dp_in; assign bus_g.en_in = en_in;

  sseg_disp_mux #(.N_DIGITS(8), .REFRESH_DIV(4), .GAP_CYC(1), .LZ_BLANK(1'b0))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  sseg_disp_mux #(.N_DIGITS(8), .REFRESH_DIV(4), .GAP_CYC(1), .LZ_BLANK(1'b1))
    dut_l (.clk(clk), .reset_n(reset_n), .bus(bus_l));
  sseg_disp_mux #(.N_DIGITS(8), .REFRESH_DIV(4), .GAP_CYC(0), .LZ_BLANK(1'b0))
    dut_g (.clk(clk), .reset_n(reset_n), .bus(bus_g));

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  // cap_* mirrors the shadow registers; eff_* is the shadow the pins reflect.
  logic [31:0] cap_hex = '0, eff_hex = '0;
  logic [7:0]  cap_dp  = '0, eff_dp  = '0;
  logic [7:0]  cap_en  = '0, eff_en  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reset(input string nm, input logic [7:0] an, input logic [3:0] hx,
                             input logic dp, input logic [2:0] idx);
    check({nm, "_rst_an_n"},    32'(an),  32'hFF);
    check({nm, "_rst_hex_out"}, 32'(hx),  32'h0);
    check({nm, "_rst_dp_n"},    32'(dp),  32'h1);
    check({nm, "_rst_dig_idx"}, 32'(idx), 32'h0);
  endtask

  // Sample k (k>=1, k-th edge after reset release) shows slot position
  // (k-1) mod (R+G) of digit ((k-1) div (R+G)) mod 8; positions >= R are gap.
  task automatic check_dut(input string nm, input logic [7:0] an, input logic [3:0] hx,
                           input logic dp, input logic [2:0] idx,
                           input int r, input int g, input bit lz);
    int         slot;
    int         pos;
    int         d;
    bit         blank;
    logic [7:0] e_an;
    logic       e_dp;
    slot  = r + g;
    pos   = (k - 1) % slot;
    d     = ((k - 1) / slot) % 8;
    blank = !eff_en[d] || (lz && d != 0 && (eff_hex >> (4 * d)) == 32'h0);
    e_an  = 8'hFF;
    e_dp  = 1'b1;
    if (pos < r && !blank) begin
      e_an[d] = 1'b0;
      e_dp    = ~eff_dp[d];
    end
    check({nm, "_an_n"},    32'(an),  32'(e_an));
    check({nm, "_dp_n"},    32'(dp),  32'(e_dp));
    check({nm, "_dig_idx"}, 32'(idx), d);
    if (pos < r) check({nm, "_hex_out"}, 32'(hx), 32'(eff_hex[4*d +: 4]));
    check({nm, "_onehot"}, 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    eff_hex = cap_hex;
    eff_dp  = cap_dp;
    eff_en  = cap_en;
    if (load) begin
      cap_hex = hex_in;
      cap_dp  = dp_in;
      cap_en  = en_in;
    end
    @(negedge clk);
    k++;
    check_dut("a", bus_a.an_n, bus_a.hex_out, bus_a.dp_n, bus_a.dig_idx, 4, 1, 1'b0);
    check_dut("l", bus_l.an_n, bus_l.hex_out, bus_l.dp_n, bus_l.dig_idx, 4, 1, 1'b1);
    check_dut("g", bus_g.an_n, bus_g.hex_out, bus_g.dp_n, bus_g.dig_idx, 4, 0, 1'b0);
  endtask

  task automatic do_load(input logic [31:0] h, input logic [7:0] e, input logic [7:0] d);
    hex_in = h;
    en_in  = e;
    dp_in  = d;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic check_reset_all();
    check_reset("a", bus_a.an_n, bus_a.hex_out, bus_a.dp_n, bus_a.dig_idx);
    check_reset("l", bus_l.an_n, bus_l.hex_out, bus_l.dp_n, bus_l.dig_idx);
    check_reset("g", bus_g.an_n, bus_g.hex_out, bus_g.dp_n, bus_g.dig_idx);
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    hex_in  = '0;
    dp_in   = '0;
    en_in   = '0;
    repeat (2) @(negedge clk);
    check_reset_all();

    // Release, then two full frames of the basic pattern (wraps 7 -> 0).
    reset_n = 1'b1;
    k       = 0;
    do_load(32'h7654_3210, 8'hFF, 8'h04);
    repeat (79) tick();

    // Upper four digits disabled: dark slots, frame length unchanged.
    do_load(32'h7654_3210, 8'h0F, 8'h04);
    repeat (39) tick();

    // Leading-zero blanking with an embedded zero, then an all-zero word.
    do_load(32'h0000_0A05, 8'hFF, 8'h00);
    repeat (39) tick();
    do_load(32'h0000_0000, 8'hFF, 8'h00);
    repeat (39) tick();

    // New word captured in the middle of digit 3's slot on the gapped unit.
    for (int i = 0; i < 40 && !(((k / 5) % 8) == 3 && (k % 5) == 1); i++) tick();
    do_load(32'h89AB_CDEF, 8'hFF, 8'h81);
    repeat (20) tick();

    // Asynchronous reset mid-slot: pins go dark before any clock edge.
    #2 reset_n = 1'b0;
    #1 check_reset_all();
    @(negedge clk);
    reset_n = 1'b1;
    k       = 0;
    cap_hex = '0; eff_hex = '0;
    cap_dp  = '0; eff_dp  = '0;
    cap_en  = '0; eff_en  = '0;

    // Load held high for two cycles re-captures; second word wins.
    hex_in = 32'h1234_5678;
    en_in  = 8'hFF;
    dp_in  = 8'h10;
    load   = 1'b1;
    tick();
    hex_in = 32'hFEDC_BA98;
    dp_in  = 8'h02;
    tick();
    load   = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
